piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 142 ++++++++++++++
 tb/tb_piso_serializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out converter with a valid/ready
// input handshake and registered serial outputs (d_out, d_valid,
// frame_start, frame_last, busy). IDLE_BITS optionally inserts a fixed
// number of idle cycles between consecutive words.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDLE_BITS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LAST = (IDLE_BITS > 0) ? 4'(IDLE_BITS - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       gap_cnt, gap_cnt_next;
    logic             d_out_next, d_valid_next, frame_start_next, frame_last_next, busy_next;
    logic             last_bit;
    logic             handshake;

    // Bit that goes on the wire first from a word in the shift register.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Advance the shift register by one bit in transmit order.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

    // in_ready is a function of state, counter and reset only, so a word
    // offered while rst is high is never accepted.
    assign in_ready  = !rst && ((state == IDLE) || (last_bit && (IDLE_BITS == 0)));
    assign handshake = in_valid && in_ready;

    // Next-state, datapath and next-output computation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next       = state;
        shreg_next       = shreg;
        cnt_next         = cnt;
        gap_cnt_next     = gap_cnt;
        d_out_next       = 1'b0;
        d_valid_next     = 1'b0;
        frame_start_next = 1'b0;
        frame_last_next  = 1'b0;

        if (handshake) begin
            // Capture the word and present its first bit next cycle.
            state_next       = SHIFT;
            shreg_next       = in_data;
            cnt_next         = '0;
            d_out_next       = first_bit(in_data);
            d_valid_next     = 1'b1;
            frame_start_next = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                SHIFT: begin
                    if (!last_bit) begin
                        shreg_next      = shift_word(shreg);
                        cnt_next        = cnt + 1'b1;
                        d_out_next      = first_bit(shreg_next);
                        d_valid_next    = 1'b1;
                        frame_last_next = (cnt_next == CNT_LAST);
                    end else if (IDLE_BITS > 0) begin
                        state_next   = GAP;
                        gap_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        gap_cnt_next = gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        busy_next = (state_next != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is cleared on reset along with the
            // control state so no stale word can reappear on d_out.
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            gap_cnt     <= '0;
            d_out       <= 1'b0;
            d_valid     <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state       <= state_next;
            shreg       <= shreg_next;
            cnt         <= cnt_next;
            gap_cnt     <= gap_cnt_next;
            d_out       <= d_out_next;
            d_valid     <= d_valid_next;
            frame_start <= frame_start_next;
            frame_last  <= frame_last_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer with three
// instances: a (MSB first, no gap), b (LSB first), c (3 idle bits).
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b, data_c;
    logic       valid_a, valid_b, valid_c;
    logic       ready_a, ready_b, ready_c;
    logic       dout_a, dout_b, dout_c;
    logic       dval_a, dval_b, dval_c;
    logic       fs_a, fs_b, fs_c;
    logic       fl_a, fl_b, fl_c;
    logic       busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BITS(0)) dut_a (
        .clk(clk), .rst(rst), .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
        .d_out(dout_a), .d_valid(dval_a), .frame_start(fs_a), .frame_last(fl_a), .busy(busy_a)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
        .d_out(dout_b), .d_valid(dval_b), .frame_start(fs_b), .frame_last(fl_b), .busy(busy_b)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BITS(3)) dut_c (
        .clk(clk), .rst(rst), .in_data(data_c), .in_valid(valid_c), .in_ready(ready_c),
        .d_out(dout_c), .d_valid(dval_c), .frame_start(fs_c), .frame_last(fl_c), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] pair;
        logic [7:0]  word;

        rst = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        data_a = 8'h00; data_b = 8'h00; data_c = 8'h00;
        tick();
        tick();

        // Reset values.
        check("rst_ready", {31'd0, ready_a}, 32'd0);
        check("rst_dout",  {31'd0, dout_a},  32'd0);
        check("rst_dval",  {31'd0, dval_a},  32'd0);
        check("rst_fs",    {31'd0, fs_a},    32'd0);
        check("rst_fl",    {31'd0, fl_a},    32'd0);
        check("rst_busy",  {31'd0, busy_a},  32'd0);

        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, ready_a}, 32'd1);

        // Single word 0xA5, MSB first; in_data changed right after capture.
        data_a = 8'hA5; valid_a = 1'b1;
        tick();
        valid_a = 1'b0; data_a = 8'h3C;
        word = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a5_dout_%0d", i),  {31'd0, dout_a},  {31'd0, word[7-i]});
            check($sformatf("a5_dval_%0d", i),  {31'd0, dval_a},  32'd1);
            check($sformatf("a5_fs_%0d", i),    {31'd0, fs_a},    {31'd0, i == 0});
            check($sformatf("a5_fl_%0d", i),    {31'd0, fl_a},    {31'd0, i == 7});
            check($sformatf("a5_busy_%0d", i),  {31'd0, busy_a},  32'd1);
            check($sformatf("a5_ready_%0d", i), {31'd0, ready_a}, {31'd0, i == 7});
            tick();
        end
        check("a5_end_dval",  {31'd0, dval_a},  32'd0);
        check("a5_end_busy",  {31'd0, busy_a},  32'd0);
        check("a5_end_ready", {31'd0, ready_a}, 32'd1);
        check("a5_end_dout",  {31'd0, dout_a},  32'd0);

        // Back-to-back 0xF0 then 0x0F with no gap.
        data_a = 8'hF0; valid_a = 1'b1;
        tick();
        data_a = 8'h0F;
        pair = 16'hF00F;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b2b_dout_%0d", i),  {31'd0, dout_a},  {31'd0, pair[15-i]});
            check($sformatf("b2b_dval_%0d", i),  {31'd0, dval_a},  32'd1);
            check($sformatf("b2b_fs_%0d", i),    {31'd0, fs_a},    {31'd0, (i == 0) || (i == 8)});
            check($sformatf("b2b_fl_%0d", i),    {31'd0, fl_a},    {31'd0, (i == 7) || (i == 15)});
            check($sformatf("b2b_ready_%0d", i), {31'd0, ready_a}, {31'd0, (i == 7) || (i == 15)});
            tick();
            if (i == 7) valid_a = 1'b0;
        end
        check("b2b_end_dval", {31'd0, dval_a}, 32'd0);
        check("b2b_end_busy", {31'd0, busy_a}, 32'd0);

        // Reset after the 4th bit of 0xFF; the word must not resume.
        data_a = 8'hFF; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ff_dout_%0d", i), {31'd0, dout_a}, 32'd1);
            if (i < 3) tick();
        end
        rst = 1'b1;
        #1;
        check("midrst_ready_in_rst", {31'd0, ready_a}, 32'd0);
        tick();
        check("midrst_dval", {31'd0, dval_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_dout", {31'd0, dout_a}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", {31'd0, ready_a}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("midrst_noresume_%0d", i), {31'd0, dval_a}, 32'd0);
        end

        // Handshake coincident with reset is discarded.
        rst = 1'b1; data_a = 8'hAA; valid_a = 1'b1;
        tick();
        rst = 1'b0; valid_a = 1'b0;
        check("rst_hs_dval", {31'd0, dval_a}, 32'd0);
        check("rst_hs_busy", {31'd0, busy_a}, 32'd0);
        tick();
        check("rst_hs_dval2", {31'd0, dval_a}, 32'd0);

        // LSB-first 0xA5 on dut_b.
        data_b = 8'hA5; valid_b = 1'b1;
        tick();
        valid_b = 1'b0; data_b = 8'h00;
        word = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lsb_dout_%0d", i), {31'd0, dout_b}, {31'd0, word[i]});
            check($sformatf("lsb_dval_%0d", i), {31'd0, dval_b}, 32'd1);
            check($sformatf("lsb_fs_%0d", i),   {31'd0, fs_b},   {31'd0, i == 0});
            check($sformatf("lsb_fl_%0d", i),   {31'd0, fl_b},   {31'd0, i == 7});
            tick();
        end
        check("lsb_end_busy", {31'd0, busy_b}, 32'd0);

        // Two queued words on dut_c with a 3-cycle gap.
        data_c = 8'hC3; valid_c = 1'b1;
        tick();
        data_c = 8'h3C;
        word = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("gap_w1_dout_%0d", i),  {31'd0, dout_c},  {31'd0, word[7-i]});
            check($sformatf("gap_w1_fl_%0d", i),    {31'd0, fl_c},    {31'd0, i == 7});
            check($sformatf("gap_w1_ready_%0d", i), {31'd0, ready_c}, 32'd0);
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            check($sformatf("gap_dval_%0d", g),  {31'd0, dval_c},  32'd0);
            check($sformatf("gap_busy_%0d", g),  {31'd0, busy_c},  32'd1);
            check($sformatf("gap_dout_%0d", g),  {31'd0, dout_c},  32'd0);
            check($sformatf("gap_ready_%0d", g), {31'd0, ready_c}, 32'd0);
            tick();
        end
        check("gap_idle_busy",  {31'd0, busy_c},  32'd0);
        check("gap_idle_dval",  {31'd0, dval_c},  32'd0);
        check("gap_idle_ready", {31'd0, ready_c}, 32'd1);
        tick();
        valid_c = 1'b0;
        word = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("gap_w2_dout_%0d", i), {31'd0, dout_c}, {31'd0, word[7-i]});
            check($sformatf("gap_w2_fs_%0d", i),   {31'd0, fs_c},   {31'd0, i == 0});
            check($sformatf("gap_w2_dval_%0d", i), {31'd0, dval_c}, 32'd1);
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            check($sformatf("gap2_busy_%0d", g), {31'd0, busy_c}, 32'd1);
            tick();
        end
        check("gap2_end_busy", {31'd0, busy_c}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
